// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - scancode constants for the prefix bytes and a few common keys
//   - receiver FSM state type
//   - parity mode constants and a parity checking helper
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_ENTER  = 8'h5A;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  // True when the received parity bit does not match the selected mode.
  function automatic logic parity_bad(input logic [7:0] data_byte,
                                      input logic par_bit,
                                      input int unsigned mode);
    case (mode)
      PAR_ODD:  return par_bit != ~^data_byte;
      PAR_EVEN: return par_bit != ^data_byte;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: two-flop synchronisers for the raw PS/2 pins plus a
// falling-edge detector on the synchronised clock.
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset (synchronisers reset to 1)
//   ps2_clk  in  raw keyboard clock, asynchronous
//   ps2_data in  raw keyboard data, asynchronous
//   fall     out synchronised PS2 clock went 1 -> 0 this cycle
//   data     out synchronised PS2 data
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    clk_prev_d  = clk_sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign data = data_sync_q[1];

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard frame receiver producing key events.
//   CLK100MHZ  in  system clock
//   CPU_RESETN in  synchronous active-low reset
//   PS2_CLK    in  raw keyboard clock, asynchronous
//   PS2_DATA   in  raw keyboard data, asynchronous
//   KEY_VALID  out one-cycle strobe, KEY_CODE/KEY_EXT/KEY_BREAK valid
//   KEY_CODE   out scancode, held until the next strobe
//   KEY_EXT    out E0 prefix preceded this code
//   KEY_BREAK  out F0 prefix preceded this code (key released)
//   FRAME_ERR  out one-cycle strobe on parity, stop-bit or timeout error
// Parameters: PARITY (0 ignore, 1 odd, 2 even), TIMEOUT (idle cycles
// mid-frame before the frame is aborted).
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned PARITY  = 1,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       KEY_VALID,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXT,
  output logic       KEY_BREAK,
  output logic       FRAME_ERR
);

  localparam logic [16:0] TMO_MAX = 17'(TIMEOUT);

  logic fall;
  logic data;

  ps2_sync_edge u_sync (
    .clk      (CLK100MHZ),
    .rst_n    (CPU_RESETN),
    .ps2_clk  (PS2_CLK),
    .ps2_data (PS2_DATA),
    .fall     (fall),
    .data     (data)
  );

  ps2_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_err_q, par_err_d;
  logic        pend_ext_q, pend_ext_d;
  logic        pend_brk_q, pend_brk_d;
  logic [16:0] tmo_q, tmo_d;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        key_ext_q, key_ext_d;
  logic        key_brk_q, key_brk_d;
  logic        frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    pend_ext_d  = pend_ext_q;
    pend_brk_d  = pend_brk_q;
    tmo_d       = tmo_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_brk_d   = key_brk_q;
    frame_err_d = 1'b0;

    // Timeout only matters when no edge arrives this cycle; an edge
    // overrides it below by clearing the counter and advancing the FSM.
    if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (!fall) begin
      if (tmo_q == TMO_MAX) begin
        frame_err_d = 1'b1;
        state_d     = ST_IDLE;
        pend_ext_d  = 1'b0;
        pend_brk_d  = 1'b0;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + 17'd1;
      end
    end

    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (!data) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_err_d = parity_bad(shift_q, data, PARITY);
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!data || par_err_q) begin
            frame_err_d = 1'b1;
            pend_ext_d  = 1'b0;
            pend_brk_d  = 1'b0;
          end else if (shift_q == PS2_EXT) begin
            pend_ext_d = 1'b1;
          end else if (shift_q == PS2_BRK) begin
            pend_brk_d = 1'b1;
          end else begin
            key_valid_d = 1'b1;
            key_code_d  = shift_q;
            key_ext_d   = pend_ext_q;
            key_brk_d   = pend_brk_q;
            pend_ext_d  = 1'b0;
            pend_brk_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      pend_ext_q  <= 1'b0;
      pend_brk_q  <= 1'b0;
      tmo_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_brk_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      pend_ext_q  <= pend_ext_d;
      pend_brk_q  <= pend_brk_d;
      tmo_q       <= tmo_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_brk_q   <= key_brk_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign KEY_VALID = key_valid_q;
  assign KEY_CODE  = key_code_q;
  assign KEY_EXT   = key_ext_q;
  assign KEY_BREAK = key_brk_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: three receivers (parity ignore / odd / even) share the
// same PS/2 pins; a per-mode reference model predicts every frame outcome.
module tb_ps2_keyboard;

  localparam int unsigned TMO = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  logic       kv [3];
  logic [7:0] kc [3];
  logic       ke [3];
  logic       kb [3];
  logic       fe [3];

  always #5 clk = ~clk;

  ps2_keyboard #(.PARITY(0), .TIMEOUT(TMO)) u_dut0 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .KEY_VALID(kv[0]), .KEY_CODE(kc[0]), .KEY_EXT(ke[0]), .KEY_BREAK(kb[0]), .FRAME_ERR(fe[0]));
  ps2_keyboard #(.PARITY(1), .TIMEOUT(TMO)) u_dut1 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .KEY_VALID(kv[1]), .KEY_CODE(kc[1]), .KEY_EXT(ke[1]), .KEY_BREAK(kb[1]), .FRAME_ERR(fe[1]));
  ps2_keyboard #(.PARITY(2), .TIMEOUT(TMO)) u_dut2 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .KEY_VALID(kv[2]), .KEY_CODE(kc[2]), .KEY_EXT(ke[2]), .KEY_BREAK(kb[2]), .FRAME_ERR(fe[2]));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and strobe monitors (sampled on the falling clock edge).
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vcnt [3] = '{0, 0, 0};
  int          ecnt [3] = '{0, 0, 0};
  int unsigned vcyc [3] = '{0, 0, 0};
  int unsigned ecyc [3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (kv[m]) begin vcnt[m]++; vcyc[m] = cyc; end
      if (fe[m]) begin ecnt[m]++; ecyc[m] = cyc; end
    end
  end

  // Reference model: pending prefixes and the last reported event per mode.
  logic       m_pext [3];
  logic       m_pbrk [3];
  logic [7:0] m_code [3];
  logic       m_ext  [3];
  logic       m_brk  [3];
  int         v0 [3];
  int         e0 [3];
  int unsigned fall_cyc;

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_pext[m] = 1'b0; m_pbrk[m] = 1'b0;
      m_code[m] = 8'h00; m_ext[m] = 1'b0; m_brk[m] = 1'b0;
    end
  endtask

  task automatic snapshot();
    for (int m = 0; m < 3; m++) begin v0[m] = vcnt[m]; e0[m] = ecnt[m]; end
  endtask

  task automatic check_held(input string ctx);
    for (int m = 0; m < 3; m++) begin
      check_eq($sformatf("%s.code[%0d]", ctx, m), 32'(kc[m]), 32'(m_code[m]));
      check_eq($sformatf("%s.ext[%0d]", ctx, m), 32'(ke[m]), 32'(m_ext[m]));
      check_eq($sformatf("%s.brk[%0d]", ctx, m), 32'(kb[m]), 32'(m_brk[m]));
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic ok;
    logic exp_v;
    int   ones;
    snapshot();
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    repeat (10) @(negedge clk);
    ones = $countones(b) + int'(par);
    for (int m = 0; m < 3; m++) begin
      case (m)
        1:       ok = stop && (ones % 2 == 1);
        2:       ok = stop && (ones % 2 == 0);
        default: ok = stop;
      endcase
      exp_v = ok && b != 8'hE0 && b != 8'hF0;
      check_eq($sformatf("frame%02h.vcnt[%0d]", b, m), 32'(vcnt[m] - v0[m]), 32'(exp_v));
      check_eq($sformatf("frame%02h.ecnt[%0d]", b, m), 32'(ecnt[m] - e0[m]), 32'(!ok));
      if (!ok) begin
        check_eq($sformatf("frame%02h.elat[%0d]", b, m), ecyc[m] - fall_cyc, 32'd3);
        m_pext[m] = 1'b0; m_pbrk[m] = 1'b0;
      end else if (b == 8'hE0) begin
        m_pext[m] = 1'b1;
      end else if (b == 8'hF0) begin
        m_pbrk[m] = 1'b1;
      end else begin
        check_eq($sformatf("frame%02h.vlat[%0d]", b, m), vcyc[m] - fall_cyc, 32'd3);
        m_code[m] = b; m_ext[m] = m_pext[m]; m_brk[m] = m_pbrk[m];
        m_pext[m] = 1'b0; m_pbrk[m] = 1'b0;
      end
    end
    check_held($sformatf("frame%02h", b));
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  task automatic send_timeout(input int nbits);
    int unsigned lat;
    snapshot();
    ps2_bit(1'b0);
    for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    repeat (TMO + 10) @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      check_eq($sformatf("tmo.ecnt[%0d]", m), 32'(ecnt[m] - e0[m]), 32'd1);
      check_eq($sformatf("tmo.vcnt[%0d]", m), 32'(vcnt[m] - v0[m]), 32'd0);
      lat = ecyc[m] - fall_cyc;
      check_eq($sformatf("tmo.lat_window[%0d] lat=%0d", m, lat),
               32'(lat >= TMO + 2 && lat <= TMO + 6), 32'd1);
      m_pext[m] = 1'b0; m_pbrk[m] = 1'b0;
    end
    check_held("tmo");
  endtask

  task automatic do_reset(input int nbits);
    snapshot();
    if (nbits > 0) begin
      ps2_bit(1'b0);
      for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    end
    ps2_data = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
    for (int m = 0; m < 3; m++) begin
      check_eq($sformatf("rst.ecnt[%0d]", m), 32'(ecnt[m] - e0[m]), 32'd0);
      check_eq($sformatf("rst.vcnt[%0d]", m), 32'(vcnt[m] - v0[m]), 32'd0);
    end
    check_held("rst");
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      check_eq($sformatf("reset.kv[%0d]", m), 32'(kv[m]), 32'd0);
      check_eq($sformatf("reset.fe[%0d]", m), 32'(fe[m]), 32'd0);
    end
    check_held("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_good(8'h1C);
    send_good(8'hF0);
    send_good(8'h12);
    send_good(8'h12);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    send_frame(8'h23, ^8'h23, 1'b1);  // wrong for odd, right for even
    send_good(8'h23);
    send_frame(8'h6B, ~^8'h6B, 1'b0); // bad stop bit
    send_good(8'hE0);
    send_timeout(4);                  // pending E0 must be dropped
    send_good(8'h5A);
    send_good(8'hF0);
    do_reset(0);
    send_good(8'h44);
    send_good(8'hE0);
    do_reset(5);
    send_good(8'h1C);

    for (int n = 0; n < 50; n++) begin
      int unsigned r;
      logic [7:0]  b;
      r = $urandom_range(0, 99);
      if (r < 6) begin
        send_timeout(int'($urandom_range(1, 10)));
      end else if (r < 10) begin
        do_reset(int'($urandom_range(0, 9)));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 20)      b = 8'hE0;
        else if (r < 40) b = 8'hF0;
        else             b = 8'($urandom_range(0, 255));
        send_frame(b, ($urandom_range(0, 99) < 80) ? ~^b : ^b,
                   ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
